cpu_imem_server: RTL

//  Memory-side responder for the cpu_ex instruction-fetch path: holds the program image and answers

---
 rtl/cpu_ex_pkg.sv | 14 +
 rtl/imem_delay_line.sv | 49 ++++
 rtl/cpu_imem_server.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_ex_pkg.sv
// Shared definitions for the cpu_ex core and its instruction-memory server.
package cpu_ex_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [DATA_W_DEF-1:0] NOP_WORD = '0;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/imem_delay_line.sv
// Fixed-latency shift of {valid, addr, data}; payload stages only move on valid,
// so the last stage holds the most recent response while idle.
module imem_delay_line #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic [LATENCY-1:0] valid_q;
    logic [ADDR_W-1:0]  addr_q [LATENCY];
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                addr_q[0] <= in_addr;
                data_q[0] <= in_data;
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    addr_q[i] <= addr_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_addr  = addr_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/cpu_imem_server.sv
// Instruction memory for cpu_ex: host loads the image, then serves fixed-latency
// in-order fetches and releases the CPU via cpu_run.
module cpu_imem_server
    import cpu_ex_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              cpu_run,
    output logic              err_oob,
    output logic              err_ld
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable and nothing aliases.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    imem_state_t       state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              ld_in_range;
    logic              fetch_in_range;
    logic              fetch_acc;
    logic              ld_wr;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  fetch_idx;
    logic [DATA_W-1:0] fetch_word;

    assign ld_in_range    = {1'b0, ld_addr} < DEPTH_LIM;
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIM;
    assign ld_idx         = ld_addr[IDX_W-1:0];
    assign fetch_idx      = fetch_addr[IDX_W-1:0];
    assign ld_wr          = (state == ST_LOAD) && ld_en && ld_in_range;
    assign fetch_acc      = fetch_req && fetch_ready;

    always_ff @(posedge clk) begin
        if (ld_wr) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_comb begin
        fetch_word = DATA_W'(NOP_WORD);
        if (fetch_in_range && written[fetch_idx]) begin
            fetch_word = mem[fetch_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_LOAD;
            cpu_run     <= 1'b0;
            fetch_ready <= 1'b0;
            err_oob     <= 1'b0;
            err_ld      <= 1'b0;
            written     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (ld_en) begin
                        if (ld_in_range) begin
                            written[ld_idx] <= 1'b1;
                        end else begin
                            err_oob <= 1'b1;
                        end
                    end
                    if (ld_done) begin
                        state       <= ST_RUN;
                        cpu_run     <= 1'b1;
                        fetch_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ld_en || ld_done) begin
                        err_ld <= 1'b1;
                    end
                    if (fetch_acc && !fetch_in_range) begin
                        err_oob <= 1'b1;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    imem_delay_line #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fetch_acc),
        .in_addr   (fetch_addr),
        .in_data   (fetch_word),
        .out_valid (rsp_valid),
        .out_addr  (rsp_addr),
        .out_data  (rsp_data)
    );

endmodule
